mnist_mem_loader: RTL and testbench
===================================

# mnist_mem_loader

Synthesizable load/compute sequencer for the MNIST NN datapath. It replaces the hand-driven load sequence with hardware: it accepts a valid/ready word stream, scatters it into `NUM_W_BANKS` weight banks and one input bank with runtime-configurable per-bank lengths, then hands the memories to compute. It sits between the external host/stream source and `mnist_nn`'s `*_oc` load ports, and drives `load_compute_ctrl` and `en_compute` until `compute_finish`.

## Interface
- `NUM_W_BANKS`, default 4: number of weight banks; must be ≤ 2^`W_SEL_LEN`.
- `W_SEL_LEN`, default 2: weight bank select width.
- `X_SEL_LEN`, default 2: input bank select width.
- `W_ADDR_LEN`, default 20: weight address width.
- `X_ADDR_LEN`, default 10: input address width.
- `DATA_LEN`, default 1: stream and memory word width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a load+compute run; sampled only in IDLE.
- `abort`  in  1  synchronous abort; returns to IDLE.
- `w_len`  in  NUM_W_BANKS*W_ADDR_LEN  word count per weight bank; bank k is at bits [k*W_ADDR_LEN +: W_ADDR_LEN]; 0 means skip the bank.
- `x_len`  in  X_ADDR_LEN  input word count; 0 means skip.
- `x_bank`  in  X_SEL_LEN  input bank target.
- `in_valid`  in  1  stream word valid.
- `in_ready`  out  1  loader can accept a word.
- `in_data`  in  DATA_LEN  stream word.
- `w_wq_oc`  out  1  weight write strobe.
- `x_wq_oc`  out  1  input write strobe.
- `w_addr_oc`  out  W_ADDR_LEN  weight write address.
- `x_addr_oc`  out  X_ADDR_LEN  input write address.
- `w_sel_oc`  out  W_SEL_LEN  weight bank select.
- `x_sel_oc`  out  X_SEL_LEN  input bank select.
- `wx_write_oc`  out  DATA_LEN  write data, shared by both banks.
- `load_compute_ctrl`  out  1  1 = load mode, 0 = compute mode.
- `en_compute`  out  1  compute enable.
- `compute_finish`  in  1  compute done, level.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at run completion.

## Operation
- Reset values:
  - IDLE state.
  - `load_compute_ctrl` = 1.
  - All other outputs = 0.
  - Bank and word counters = 0.
- States and transitions:
  - IDLE → LOAD_W on `start`.
  - LOAD_W loads bank b, starting at b = 0.
  - LOAD_X loads the input bank.
  - COMPUTE runs until `compute_finish`.
  - DONE lasts one cycle, then returns to IDLE.
- `w_len`, `x_len` and `x_bank` are captured into registers on `start`; later changes have no effect on the run.
- LOAD_W:
  - If `len[b]` = 0: `in_ready` = 0 for one cycle and b increments (skip costs 1 cycle).
  - Otherwise `in_ready` = 1. Each handshake (`in_valid & in_ready`) writes address `cnt` of bank b.
  - On the handshake with `cnt == len[b]-1`: `cnt` ← 0 and b ← b+1.
  - After bank `NUM_W_BANKS-1` the FSM moves to LOAD_X.
- LOAD_X: same behaviour against `x_len`. Writes go to `x_bank`. After the last word, or immediately if `x_len` = 0, the FSM moves to COMPUTE.
- COMPUTE: `load_compute_ctrl` = 0 and `en_compute` = 1, held until `compute_finish` is sampled high. Then the FSM moves to DONE.
- DONE: `done` = 1, `en_compute` = 0, `load_compute_ctrl` = 1. Next state is IDLE.
- `start` while busy is ignored.
- `abort` in any state: next cycle is IDLE. All strobes, `en_compute`, `busy` and `done` are 0, and `load_compute_ctrl` = 1. `abort` has priority over a same-cycle handshake; that word is dropped.
- `in_ready` is 0 in IDLE, COMPUTE and DONE.

## Timing
- All outputs are registered.
- A handshake at edge N produces the write strobe, address, select and data valid during cycle N+1, for exactly one cycle per word.
- Back-to-back handshakes give back-to-back writes with no bubble, including across a bank boundary.
- `in_ready` is combinational from state and counters only; it never depends on `in_valid`.
- The final input write strobe occurs in the same cycle that `load_compute_ctrl` falls, so the memory sees the last write in load mode.
- `en_compute` rises 1 cycle after the last write handshake.
- `done` pulses 1 cycle after `compute_finish` is sampled.
- Counter widths equal the address widths; `cnt` never exceeds `len-1`, so no wrap is possible.

## Structure
- Shared package `mnist_nn_pkg` holds:
  - the state enum (`IDLE`, `LOAD_W`, `LOAD_X`, `COMPUTE`, `DONE`);
  - the default width constants, shared with `mnist_nn`.
- One natural sub-module: `bank_addr_counter`. It holds the word counter with length compare and raises a `last` flag. It is instantiated once; the weight and input phases share it, with the length muxed by state.

## Test plan
- Lengths {6,9,9,9}, `x_len` = 2, `in_valid` held 1 → 35 writes with no gaps. `w_sel_oc` steps 0,1,2,3. Addresses restart at 0 per bank. `x_addr_oc` = 0,1. `en_compute` rises 1 cycle after the last handshake.
- `w_len` = {3,0,0,2}, `x_len` = 0 → banks 1 and 2 are skipped with 1 cycle each and no strobe. Straight to COMPUTE after bank 3 address 1.
- Random `in_valid` gaps with the {6,9,9,9} lengths → the write sequence is identical to the first test, with a strobe only in the cycle after each handshake.
- `compute_finish` asserted 50 cycles into COMPUTE → `done` pulses once, then `busy` = 0, `load_compute_ctrl` = 1, and a new `start` is accepted.
- `abort` in the same cycle as a handshake mid bank 2 → no strobe, IDLE next cycle. A new `start` then reloads from bank 0 address 0.
- Async `rst` asserted mid LOAD_X → all outputs go to reset values immediately, without a clock edge. `start` during COMPUTE is ignored.

Source files
------------

// File: rtl/mnist_nn_pkg.sv
// -----------------------------------------------------------------------------
// mnist_nn_pkg
// Shared definitions for the MNIST NN datapath and its load/compute sequencer.
//   - default width constants (shared with mnist_nn)
//   - sequencer state encoding
// -----------------------------------------------------------------------------
package mnist_nn_pkg;

    localparam int unsigned DEF_NUM_W_BANKS = 4;
    localparam int unsigned DEF_W_SEL_LEN   = 2;
    localparam int unsigned DEF_X_SEL_LEN   = 2;
    localparam int unsigned DEF_W_ADDR_LEN  = 20;
    localparam int unsigned DEF_X_ADDR_LEN  = 10;
    localparam int unsigned DEF_DATA_LEN    = 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_X  = 3'd2,
        COMPUTE = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/mnist_mem_loader_if.sv
// -----------------------------------------------------------------------------
// mnist_mem_loader_if
// Bundles every non-clock/reset signal of mnist_mem_loader.
//   slave  : loader view (stream in, memory load ports and control out)
//   master : host / stream source / mnist_nn view
// Signals: start, abort, w_len, x_len, x_bank, in_valid/in_ready/in_data,
//          w_wq_oc, x_wq_oc, w_addr_oc, x_addr_oc, w_sel_oc, x_sel_oc,
//          wx_write_oc, load_compute_ctrl, en_compute, compute_finish,
//          busy, done.
// -----------------------------------------------------------------------------
interface mnist_mem_loader_if
    import mnist_nn_pkg::*;
#(
    parameter int unsigned NUM_W_BANKS = DEF_NUM_W_BANKS,
    parameter int unsigned W_SEL_LEN   = DEF_W_SEL_LEN,
    parameter int unsigned X_SEL_LEN   = DEF_X_SEL_LEN,
    parameter int unsigned W_ADDR_LEN  = DEF_W_ADDR_LEN,
    parameter int unsigned X_ADDR_LEN  = DEF_X_ADDR_LEN,
    parameter int unsigned DATA_LEN    = DEF_DATA_LEN
);
    logic                              start;
    logic                              abort;
    logic [NUM_W_BANKS*W_ADDR_LEN-1:0] w_len;
    logic [X_ADDR_LEN-1:0]             x_len;
    logic [X_SEL_LEN-1:0]              x_bank;
    logic                              in_valid;
    logic                              in_ready;
    logic [DATA_LEN-1:0]               in_data;
    logic                              w_wq_oc;
    logic                              x_wq_oc;
    logic [W_ADDR_LEN-1:0]             w_addr_oc;
    logic [X_ADDR_LEN-1:0]             x_addr_oc;
    logic [W_SEL_LEN-1:0]              w_sel_oc;
    logic [X_SEL_LEN-1:0]              x_sel_oc;
    logic [DATA_LEN-1:0]               wx_write_oc;
    logic                              load_compute_ctrl;
    logic                              en_compute;
    logic                              compute_finish;
    logic                              busy;
    logic                              done;

    modport slave (
        input  start, abort, w_len, x_len, x_bank, in_valid, in_data, compute_finish,
        output in_ready, w_wq_oc, x_wq_oc, w_addr_oc, x_addr_oc, w_sel_oc, x_sel_oc,
               wx_write_oc, load_compute_ctrl, en_compute, busy, done
    );

    modport master (
        output start, abort, w_len, x_len, x_bank, in_valid, in_data, compute_finish,
        input  in_ready, w_wq_oc, x_wq_oc, w_addr_oc, x_addr_oc, w_sel_oc, x_sel_oc,
               wx_write_oc, load_compute_ctrl, en_compute, busy, done
    );

endinterface

// File: rtl/bank_addr_counter.sv
// -----------------------------------------------------------------------------
// bank_addr_counter
// Word counter for one bank load with length compare.
//   clk_i, rst_i : clock, async active-high reset
//   clr_i        : synchronous clear to 0 (wins over inc_i)
//   inc_i        : accepted word; advances, wrapping to 0 after the last word
//   len_i        : word count of the current bank
//   cnt_o        : current word address
//   last_o       : cnt_o is the final word of the bank (cnt == len-1)
//   empty_o      : len_i == 0, bank is skipped
// -----------------------------------------------------------------------------
module bank_addr_counter #(
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] len_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             last_o,
    output logic             empty_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign cnt_o   = cnt_q;
    assign last_o  = (cnt_q == len_i - WIDTH'(1));
    assign empty_o = (len_i == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i)
            cnt_d = last_o ? '0 : cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mnist_mem_loader.sv
// -----------------------------------------------------------------------------
// mnist_mem_loader
// Load/compute sequencer: scatters a valid/ready word stream into NUM_W_BANKS
// weight banks and one input bank, then runs compute until compute_finish.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mnist_mem_loader_if.slave (run control, stream, memory load
//              ports, compute control, status)
// All outputs are registered except in_ready (state/counter decode) and busy
// (state register decode).
// -----------------------------------------------------------------------------
module mnist_mem_loader
    import mnist_nn_pkg::*;
#(
    parameter int unsigned NUM_W_BANKS = DEF_NUM_W_BANKS,
    parameter int unsigned W_SEL_LEN   = DEF_W_SEL_LEN,
    parameter int unsigned X_SEL_LEN   = DEF_X_SEL_LEN,
    parameter int unsigned W_ADDR_LEN  = DEF_W_ADDR_LEN,
    parameter int unsigned X_ADDR_LEN  = DEF_X_ADDR_LEN,
    parameter int unsigned DATA_LEN    = DEF_DATA_LEN
) (
    input  logic               clk,
    input  logic               rst,
    mnist_mem_loader_if.slave  bus
);
    // One counter serves both phases, so it is as wide as the wider address.
    localparam int unsigned CNT_LEN = (W_ADDR_LEN > X_ADDR_LEN) ? W_ADDR_LEN : X_ADDR_LEN;

    state_t                            state_q, state_d;
    logic [W_SEL_LEN-1:0]              bank_q, bank_d;
    logic [NUM_W_BANKS*W_ADDR_LEN-1:0] w_len_q, w_len_d;
    logic [X_ADDR_LEN-1:0]             x_len_q, x_len_d;
    logic [X_SEL_LEN-1:0]              x_bank_q, x_bank_d;
    logic                              w_wq_q, w_wq_d;
    logic                              x_wq_q, x_wq_d;
    logic [W_ADDR_LEN-1:0]             w_addr_q, w_addr_d;
    logic [X_ADDR_LEN-1:0]             x_addr_q, x_addr_d;
    logic [W_SEL_LEN-1:0]              w_sel_q, w_sel_d;
    logic [X_SEL_LEN-1:0]              x_sel_q, x_sel_d;
    logic [DATA_LEN-1:0]               wdata_q, wdata_d;
    logic                              lcc_q, lcc_d;
    logic                              en_q, en_d;
    logic                              done_q, done_d;

    logic [CNT_LEN-1:0] cur_len;
    logic [CNT_LEN-1:0] cnt;
    logic               last;
    logic               empty;
    logic               ready;
    logic               hs;

    // Length of the bank currently being loaded.
    always_comb begin
        cur_len = CNT_LEN'(x_len_q);
        if (state_q == LOAD_W) begin
            cur_len = '0;
            for (int unsigned k = 0; k < NUM_W_BANKS; k++)
                if (bank_q == W_SEL_LEN'(k))
                    cur_len = CNT_LEN'(w_len_q[k*W_ADDR_LEN +: W_ADDR_LEN]);
        end
    end

    assign ready = ((state_q == LOAD_W) || (state_q == LOAD_X)) && !empty;
    // A handshake coinciding with abort is dropped.
    assign hs    = ready && bus.in_valid && !bus.abort;

    bank_addr_counter #(.WIDTH(CNT_LEN)) u_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (bus.abort || (state_q == IDLE)),
        .inc_i   (hs),
        .len_i   (cur_len),
        .cnt_o   (cnt),
        .last_o  (last),
        .empty_o (empty)
    );

    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        w_len_d  = w_len_q;
        x_len_d  = x_len_q;
        x_bank_d = x_bank_q;
        w_addr_d = w_addr_q;
        x_addr_d = x_addr_q;
        w_sel_d  = w_sel_q;
        x_sel_d  = x_sel_q;
        wdata_d  = wdata_q;
        lcc_d    = lcc_q;
        en_d     = en_q;
        w_wq_d   = 1'b0;
        x_wq_d   = 1'b0;
        done_d   = 1'b0;

        if (bus.abort) begin
            state_d = IDLE;
            bank_d  = '0;
            lcc_d   = 1'b1;
            en_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        w_len_d  = bus.w_len;
                        x_len_d  = bus.x_len;
                        x_bank_d = bus.x_bank;
                        bank_d   = '0;
                        state_d  = LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (hs) begin
                        w_wq_d   = 1'b1;
                        w_addr_d = W_ADDR_LEN'(cnt);
                        w_sel_d  = bank_q;
                        wdata_d  = bus.in_data;
                    end
                    if (empty || (hs && last)) begin
                        if (bank_q == W_SEL_LEN'(NUM_W_BANKS - 1)) begin
                            bank_d  = '0;
                            state_d = LOAD_X;
                        end else begin
                            bank_d = bank_q + W_SEL_LEN'(1);
                        end
                    end
                end
                LOAD_X: begin
                    if (hs) begin
                        x_wq_d   = 1'b1;
                        x_addr_d = X_ADDR_LEN'(cnt);
                        x_sel_d  = x_bank_q;
                        wdata_d  = bus.in_data;
                    end
                    // Mode flips on the same edge as the final write, so the
                    // last strobe and load_compute_ctrl falling share a cycle.
                    if (empty || (hs && last)) begin
                        state_d = COMPUTE;
                        lcc_d   = 1'b0;
                        en_d    = 1'b1;
                    end
                end
                COMPUTE: begin
                    if (bus.compute_finish) begin
                        state_d = DONE;
                        lcc_d   = 1'b1;
                        en_d    = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bank_q   <= '0;
            w_len_q  <= '0;
            x_len_q  <= '0;
            x_bank_q <= '0;
            w_wq_q   <= 1'b0;
            x_wq_q   <= 1'b0;
            w_addr_q <= '0;
            x_addr_q <= '0;
            w_sel_q  <= '0;
            x_sel_q  <= '0;
            wdata_q  <= '0;
            lcc_q    <= 1'b1;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bank_q   <= bank_d;
            w_len_q  <= w_len_d;
            x_len_q  <= x_len_d;
            x_bank_q <= x_bank_d;
            w_wq_q   <= w_wq_d;
            x_wq_q   <= x_wq_d;
            w_addr_q <= w_addr_d;
            x_addr_q <= x_addr_d;
            w_sel_q  <= w_sel_d;
            x_sel_q  <= x_sel_d;
            wdata_q  <= wdata_d;
            lcc_q    <= lcc_d;
            en_q     <= en_d;
            done_q   <= done_d;
        end
    end

    assign bus.in_ready          = ready;
    assign bus.w_wq_oc           = w_wq_q;
    assign bus.x_wq_oc           = x_wq_q;
    assign bus.w_addr_oc         = w_addr_q;
    assign bus.x_addr_oc         = x_addr_q;
    assign bus.w_sel_oc          = w_sel_q;
    assign bus.x_sel_oc          = x_sel_q;
    assign bus.wx_write_oc       = wdata_q;
    assign bus.load_compute_ctrl = lcc_q;
    assign bus.en_compute        = en_q;
    assign bus.busy              = (state_q != IDLE);
    assign bus.done              = done_q;

endmodule

// File: tb/tb_mnist_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_mnist_mem_loader
// Randomized stimulus against a slot-list reference model: at start the run is
// expanded into an ordered list of slots (one per skipped bank, one per word),
// and the model consumes one slot per skip cycle or per accepted word.
// -----------------------------------------------------------------------------
module tb_mnist_mem_loader;
    localparam int unsigned NB = 4;
    localparam int unsigned WS = 2;
    localparam int unsigned XS = 2;
    localparam int unsigned WA = 20;
    localparam int unsigned XA = 10;
    localparam int unsigned DL = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mnist_mem_loader_if #(.NUM_W_BANKS(NB), .W_SEL_LEN(WS), .X_SEL_LEN(XS),
                          .W_ADDR_LEN(WA), .X_ADDR_LEN(XA), .DATA_LEN(DL)) bus ();

    mnist_mem_loader #(.NUM_W_BANKS(NB), .W_SEL_LEN(WS), .X_SEL_LEN(XS),
                       .W_ADDR_LEN(WA), .X_ADDR_LEN(XA), .DATA_LEN(DL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int obs_w = 0, obs_x = 0, obs_done = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          skip;
        bit          is_x;
        int unsigned sel;
        int unsigned addr;
    } slot_t;

    slot_t       slots[$];
    slot_t       s;
    int          m_phase = 0;   // 0 idle, 1 loading, 2 computing, 3 finished
    bit          ew = 0, ex = 0;
    int unsigned e_sel = 0, e_addr = 0, e_data = 0;

    task automatic build_run();
        int unsigned len;
        slot_t t;
        slots.delete();
        for (int unsigned k = 0; k < NB; k++) begin
            len = int'(bus.w_len[k*WA +: WA]);
            if (len == 0) begin
                t = '{skip: 1'b1, is_x: 1'b0, sel: k, addr: 0};
                slots.push_back(t);
            end else begin
                for (int unsigned a = 0; a < len; a++) begin
                    t = '{skip: 1'b0, is_x: 1'b0, sel: k, addr: a};
                    slots.push_back(t);
                end
            end
        end
        len = int'(bus.x_len);
        if (len == 0) begin
            t = '{skip: 1'b1, is_x: 1'b1, sel: 0, addr: 0};
            slots.push_back(t);
        end else begin
            for (int unsigned a = 0; a < len; a++) begin
                t = '{skip: 1'b0, is_x: 1'b1, sel: int'(bus.x_bank), addr: a};
                slots.push_back(t);
            end
        end
    endtask

    function automatic bit model_ready();
        return (m_phase == 1) && (slots.size() > 0) && !slots[0].skip;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_phase = 0;
            slots.delete();
            ew = 0;
            ex = 0;
        end else begin
            ew = 0;
            ex = 0;
            if (bus.abort) begin
                m_phase = 0;
                slots.delete();
            end else begin
                case (m_phase)
                    0: if (bus.start) begin build_run(); m_phase = 1; end
                    1: begin
                        if (slots[0].skip) begin
                            void'(slots.pop_front());
                        end else if (bus.in_valid) begin
                            s = slots.pop_front();
                            ew = !s.is_x;
                            ex = s.is_x;
                            e_sel = s.sel;
                            e_addr = s.addr;
                            e_data = int'(bus.in_data);
                        end
                        if (slots.size() == 0) m_phase = 2;
                    end
                    2: if (bus.compute_finish) m_phase = 3;
                    default: m_phase = 0;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        chk("in_ready", bus.in_ready, model_ready());
        chk("w_wq_oc", bus.w_wq_oc, ew);
        chk("x_wq_oc", bus.x_wq_oc, ex);
        if (ew) begin
            chk("w_sel_oc", bus.w_sel_oc, e_sel);
            chk("w_addr_oc", bus.w_addr_oc, e_addr);
            chk("w_data", bus.wx_write_oc, e_data);
        end
        if (ex) begin
            chk("x_sel_oc", bus.x_sel_oc, e_sel);
            chk("x_addr_oc", bus.x_addr_oc, e_addr);
            chk("x_data", bus.wx_write_oc, e_data);
        end
        chk("load_compute_ctrl", bus.load_compute_ctrl, m_phase != 2);
        chk("en_compute", bus.en_compute, m_phase == 2);
        chk("done", bus.done, m_phase == 3);
        chk("busy", bus.busy, m_phase != 0);
        if (bus.w_wq_oc) obs_w++;
        if (bus.x_wq_oc) obs_x++;
        if (bus.done)    obs_done++;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [NB*WA-1:0] pack4(input int unsigned a, b, c, d);
        logic [NB*WA-1:0] r;
        r = '0;
        r[0*WA +: WA] = WA'(a);
        r[1*WA +: WA] = WA'(b);
        r[2*WA +: WA] = WA'(c);
        r[3*WA +: WA] = WA'(d);
        return r;
    endfunction

    // Starts a run and streams words until en_compute rises; lat is the number
    // of edges from the start edge to the edge that raised en_compute.
    task automatic run_load(input logic [NB*WA-1:0] wl, input int unsigned xl,
                            input int unsigned xb, input int unsigned gap_pct,
                            output int lat);
        int s0;
        bit got;
        obs_w = 0; obs_x = 0; obs_done = 0;
        bus.w_len  = wl;
        bus.x_len  = XA'(xl);
        bus.x_bank = XS'(xb);
        bus.start  = 1'b1;
        s0 = cyc + 1;
        step();
        bus.start  = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        bus.w_len  = '1;   // later changes must not affect the run
        bus.x_len  = '1;
        got = 0;
        lat = -1;
        for (int i = 0; i < 3000 && !got; i++) begin
            bus.in_valid = ($urandom_range(0, 99) >= gap_pct);
            bus.in_data  = DL'($urandom);
            step();
            if (bus.en_compute) begin
                got = 1;
                lat = cyc - s0;
            end
        end
        bus.in_valid = 1'b0;
        if (!got) chk("load_timeout", 0, 1);
    endtask

    task automatic finish_after(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            bus.start = (i == 10);   // must be ignored while computing
            step();
        end
        bus.start = 1'b0;
        bus.compute_finish = 1'b1;
        step();
        bus.compute_finish = 1'b0;
        step();
        step();
        chk("done_pulses", obs_done, 1);
        chk("busy_after_done", bus.busy, 0);
        chk("lcc_after_done", bus.load_compute_ctrl, 1);
    endtask

    int lat;

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.abort = 0; bus.w_len = '0; bus.x_len = '0; bus.x_bank = '0;
        bus.in_valid = 0; bus.in_data = '0; bus.compute_finish = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_lcc", bus.load_compute_ctrl, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_en", bus.en_compute, 0);
        chk("rst_w_addr", bus.w_addr_oc, 0);
        rst = 1'b0;
        step();

        // Full load, no gaps: 35 back-to-back writes.
        run_load(pack4(6, 9, 9, 9), 2, 1, 0, lat);
        chk("t1_latency", lat, 35);
        finish_after(3);
        chk("t1_w_writes", obs_w, 33);
        chk("t1_x_writes", obs_x, 2);

        // Skipped banks and empty input bank.
        run_load(pack4(3, 0, 0, 2), 0, 0, 0, lat);
        chk("t2_latency", lat, 8);
        finish_after(2);
        chk("t2_w_writes", obs_w, 5);
        chk("t2_x_writes", obs_x, 0);

        // Random valid gaps, compute_finish 50 cycles into COMPUTE.
        run_load(pack4(6, 9, 9, 9), 2, 3, 40, lat);
        finish_after(50);
        chk("t3_w_writes", obs_w, 33);
        chk("t3_x_writes", obs_x, 2);

        // Abort together with a handshake at bank 2 address 3.
        obs_w = 0;
        bus.w_len = pack4(6, 9, 9, 9); bus.x_len = XA'(2); bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        repeat (18) begin bus.in_data = DL'($urandom); step(); end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_no_strobe", bus.w_wq_oc, 0);
        chk("abort_writes_before", obs_w, 18);
        step();
        run_load(pack4(6, 9, 9, 9), 2, 1, 0, lat);
        chk("t4_latency", lat, 35);
        finish_after(4);

        // Async reset in the middle of LOAD_X.
        bus.w_len = pack4(6, 9, 9, 9); bus.x_len = XA'(2); bus.x_bank = XS'(2);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        repeat (34) begin bus.in_data = DL'($urandom); step(); end
        bus.in_valid = 1'b0;
        chk("pre_rst_x_wq", bus.x_wq_oc, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_x_wq", bus.x_wq_oc, 0);
        chk("arst_x_sel", bus.x_sel_oc, 0);
        chk("arst_w_sel", bus.w_sel_oc, 0);
        chk("arst_w_addr", bus.w_addr_oc, 0);
        chk("arst_in_ready", bus.in_ready, 0);
        chk("arst_lcc", bus.load_compute_ctrl, 1);
        chk("arst_busy", bus.busy, 0);
        step();
        rst = 1'b0;
        step();

        // Random runs.
        for (int r = 0; r < 8; r++) begin
            run_load(pack4($urandom_range(0, 4), $urandom_range(0, 4),
                           $urandom_range(0, 4), $urandom_range(0, 4)),
                     $urandom_range(0, 4), $urandom_range(0, 3),
                     $urandom_range(0, 60), lat);
            finish_after($urandom_range(1, 15));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
